// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package rr_arbiter_4_pkg;

  localparam int ARB_N = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N-1:0] arb_onehot(input logic [1:0] idx);
    return ARB_N'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester/target handshake bundle between the requesters and the arbiter.
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [ARB_N-1:0] i_req;
  logic             i_ack;
  logic [1:0]       o_sel;
  logic [ARB_N-1:0] o_gnt;
  logic             o_valid;
  logic [ARB_N-1:0] o_done;
  logic             o_err;

  modport master (
    output i_req, i_ack,
    input  o_sel, o_gnt, o_valid, o_done, o_err
  );

  modport slave (
    input  i_req, i_ack,
    output o_sel, o_gnt, o_valid, o_done, o_err
  );

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin priority encoder: first set request after ptr, wrapping to ptr itself.
module rr_pick_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       ptr,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [1:0] cand;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = ARB_N; k >= 1; k--) begin
      cand = 2'(int'(ptr) + k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter that holds one grant per transaction and drives the shared Mux4 select.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
)
(
  input  logic           i_clk,
  input  logic           i_rst,
  rr_arbiter_4_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [ARB_N-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic             timeout_hit;
  logic             valid;

  rr_pick_4 u_pick (
    .req   (bus.i_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign valid       = (state_q == ARB_GRANT);

  // Ack beats withdrawal, withdrawal beats timeout; only the timeout path raises err.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          sel_d   = pick_idx;
          ptr_d   = pick_idx;
          gnt_d   = arb_onehot(pick_idx);
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (bus.i_ack) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end else if (!bus.i_req[sel_q]) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // A reset cycle never reports completion, even if ack arrives with it.
  assign bus.o_done  = (valid && bus.i_ack && !i_rst) ? gnt_q : '0;
  assign bus.o_sel   = sel_q;
  assign bus.o_gnt   = gnt_q;
  assign bus.o_valid = valid;
  assign bus.o_err   = err_q;

endmodule
